calc_btn_cond: RTL

- Input-conditioning stage directly upstream of the calc accumulator block.
- Takes raw board buttons btnc/btnl/btnr/btnd and switches sw[15:0]; synchronizes them, debounces the buttons, and turns each btnd press into a single-cycle enter strobe.
- On that strobe, captures a coherent operand/op-select snapshot, so calc sees stable op bits and operand on exactly one clock edge per press.

---
 rtl/calc_btn_cond.sv | 77 +++++++
 1 files changed

// File: rtl/calc_btn_cond.sv
// calc_btn_cond: synchronizes switches, debounces buttons, and issues one enter strobe per btnd press with a coherent op/operand snapshot
module calc_btn_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000000
) (
    input  logic        clk,
    input  logic        btnu,
    input  logic        btnc_raw,
    input  logic        btnl_raw,
    input  logic        btnr_raw,
    input  logic        btnd_raw,
    input  logic [15:0] sw_raw,
    output logic        btnc,
    output logic        btnl,
    output logic        btnr,
    output logic        btnd,
    output logic [15:0] sw,
    output logic        busy
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0][19:0] syncPipe;
    logic [3:0]                   btnSync;
    logic [15:0]                  swSync;
    logic [3:0][CNT_W-1:0]        cnt;
    logic [3:0]                   dbLevel;
    logic                         dPrev;
    logic                         enterRise;

    assign {btnSync, swSync} = syncPipe[SYNC_STAGES-1];
    assign busy              = |cnt;
    assign enterRise         = dbLevel[3] & ~dPrev;

    // Shift raw buttons {d,r,l,c} and switches through the synchronizer chain
    always_ff @(posedge clk or posedge btnu)
        if (btnu) syncPipe <= '0;
        else      syncPipe <= {syncPipe[SYNC_STAGES-2:0], {btnd_raw, btnr_raw, btnl_raw, btnc_raw, sw_raw}};

    // Per-button debounce: a nonzero counter means a level change is being qualified
    always_ff @(posedge clk or posedge btnu)
        if (btnu) begin
            cnt     <= '0;
            dbLevel <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btnSync[i] == dbLevel[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    cnt[i]     <= '0;
                    dbLevel[i] <= ~dbLevel[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end

    // Strobe one cycle after debounced enter rises and snapshot op bits and operand on that same edge
    always_ff @(posedge clk or posedge btnu)
        if (btnu) begin
            dPrev <= 1'b0;
            btnd  <= 1'b0;
            btnc  <= 1'b0;
            btnl  <= 1'b0;
            btnr  <= 1'b0;
            sw    <= '0;
        end else begin
            dPrev <= dbLevel[3];
            btnd  <= enterRise;
            if (enterRise) begin
                btnc <= dbLevel[0];
                btnl <= dbLevel[1];
                btnr <= dbLevel[2];
                sw   <= swSync;
            end
        end
endmodule
